// File: rtl/adc_seq_pkg.sv
// Shared definitions for the LTC2494 scan sequencer: FSM encoding, the
// configuration word layout and the received-word field positions.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_WAIT
  } state_e;

  localparam logic [2:0] CFG_PREAMBLE = 3'b101;
  localparam int         CFG_EN_BIT   = 28;
  localparam int         CFG_SGL_BIT  = 27;
  localparam int         CFG_ODD_BIT  = 26;
  localparam int         CFG_ADDR_LSB = 23;
  localparam int         CFG_EN2_BIT  = 22;
  localparam int         CFG_IM_BIT   = 21;
  localparam int         CFG_FAFB_LSB = 19;
  localparam int         CFG_SPD_BIT  = 18;
  localparam int         CFG_GAIN_LSB = 15;

  localparam logic       CFG_EN   = 1'b1;
  localparam logic       CFG_SGL  = 1'b1;
  localparam logic       CFG_EN2  = 1'b1;
  localparam logic       CFG_IM   = 1'b0;
  localparam logic [1:0] CFG_FAFB = 2'b00;
  localparam logic       CFG_SPD  = 1'b0;

  localparam int EOC_BIT = 31;
  localparam int RES_MSB = 29;
  localparam int RES_LSB = 6;

  localparam logic [31:0] RESET_WORD = 32'h8000_0000;

  // Single-ended conversion on channel ch; ODD selects the odd input of the pair.
  function automatic logic [31:0] cfg_word(input logic [3:0] ch, input logic [2:0] gain);
    logic [31:0] w;
    w                      = '0;
    w[31:29]               = CFG_PREAMBLE;
    w[CFG_EN_BIT]          = CFG_EN;
    w[CFG_SGL_BIT]         = CFG_SGL;
    w[CFG_ODD_BIT]         = ch[0];
    w[CFG_ADDR_LSB +: 3]   = ch[3:1];
    w[CFG_EN2_BIT]         = CFG_EN2;
    w[CFG_IM_BIT]          = CFG_IM;
    w[CFG_FAFB_LSB +: 2]   = CFG_FAFB;
    w[CFG_SPD_BIT]         = CFG_SPD;
    w[CFG_GAIN_LSB +: 3]   = gain;
    return w;
  endfunction

endpackage

// File: rtl/chan_rr_pick.sv
// Round-robin channel picker: lowest set mask bit strictly above cur,
// wrapping 15 -> 0. A single-bit mask picks the same channel again.
module chan_rr_pick (
  input  logic [15:0] mask,
  input  logic [3:0]  cur,
  output logic [3:0]  next,
  output logic        any
);

  logic [3:0] idx;
  logic       found;

  always_comb begin
    next  = cur;
    found = 1'b0;
    idx   = cur;
    for (int i = 1; i <= 16; i++) begin
      idx = cur + 4'(i);
      if (!found && mask[idx]) begin
        next  = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scan scheduler for the LTC2494 SPI path. Each transfer configures the next
// conversion and returns the previous one, so results are tagged one step late.
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int CONV_CYCLES = 7500000,
  parameter int CNT_W       = 23,
  parameter int NCH         = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_enable,
  input  logic [NCH-1:0] i_chanMask,
  input  logic [2:0]     i_gain,
  input  logic           i_ready,
  output logic           o_dataValid,
  output logic [31:0]    o_DATA,
  input  logic           i_rxValid,
  input  logic [31:0]    i_rxData,
  output logic [23:0]    o_result,
  output logic [3:0]     o_resultCh,
  output logic           o_resultValid,
  output logic           o_eocErr,
  output logic           o_busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       cur_ch_q, cur_ch_d;
  logic [3:0]       pend_ch_q, pend_ch_d;
  logic             prev_valid_q, prev_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic [23:0]      result_q, result_d;
  logic [3:0]       result_ch_q, result_ch_d;
  logic             result_valid_q, result_valid_d;
  logic             eoc_err_q, eoc_err_d;

  logic [3:0]       next_ch;
  logic             mask_any;
  logic             unused_rx_bits;

  chan_rr_pick u_pick (
    .mask (i_chanMask),
    .cur  (cur_ch_q),
    .next (next_ch),
    .any  (mask_any)
  );

  assign unused_rx_bits = ^{i_rxData[30], i_rxData[RES_LSB-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An emptied mask in ISSUE abandons the scan before any word is handed over.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_enable && mask_any) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!mask_any)    state_d = ST_IDLE;
        else if (i_ready) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (i_rxValid) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = (i_enable && mask_any) ? ST_ISSUE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_ch_d       = cur_ch_q;
    pend_ch_d      = pend_ch_q;
    prev_valid_d   = prev_valid_q;
    cnt_d          = cnt_q;
    data_d         = data_q;
    data_valid_d   = 1'b0;
    result_d       = result_q;
    result_ch_d    = result_ch_q;
    result_valid_d = 1'b0;
    eoc_err_d      = eoc_err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_enable && mask_any) begin
          eoc_err_d    = 1'b0;
          prev_valid_d = 1'b0;
          cur_ch_d     = 4'hF;
        end
      end
      ST_ISSUE: begin
        if (mask_any && i_ready) begin
          data_d       = cfg_word(next_ch, i_gain);
          data_valid_d = 1'b1;
          pend_ch_d    = cur_ch_q;
          cur_ch_d     = next_ch;
        end
      end
      ST_XFER: begin
        // The word coming back belongs to the channel configured one transfer earlier.
        if (i_rxValid) begin
          if (prev_valid_q) begin
            if (i_rxData[EOC_BIT]) begin
              eoc_err_d = 1'b1;
            end else begin
              result_d       = i_rxData[RES_MSB:RES_LSB];
              result_ch_d    = pend_ch_q;
              result_valid_d = 1'b1;
            end
          end
          prev_valid_d = 1'b1;
          cnt_d        = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_ch_q       <= '0;
      pend_ch_q      <= '0;
      prev_valid_q   <= 1'b0;
      cnt_q          <= '0;
      data_q         <= RESET_WORD;
      data_valid_q   <= 1'b0;
      result_q       <= '0;
      result_ch_q    <= '0;
      result_valid_q <= 1'b0;
      eoc_err_q      <= 1'b0;
    end else begin
      cur_ch_q       <= cur_ch_d;
      pend_ch_q      <= pend_ch_d;
      prev_valid_q   <= prev_valid_d;
      cnt_q          <= cnt_d;
      data_q         <= data_d;
      data_valid_q   <= data_valid_d;
      result_q       <= result_d;
      result_ch_q    <= result_ch_d;
      result_valid_q <= result_valid_d;
      eoc_err_q      <= eoc_err_d;
    end
  end

  assign o_dataValid   = data_valid_q;
  assign o_DATA        = data_q;
  assign o_result      = result_q;
  assign o_resultCh    = result_ch_q;
  assign o_resultValid = result_valid_q;
  assign o_eocErr      = eoc_err_q;
  assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a simple SPI master / ADC model
// that answers each word 8 cycles after it is issued.
module tb_adc_scan_sequencer;

  localparam int CONV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic [15:0] i_chanMask;
  logic [2:0]  i_gain;
  logic        i_ready;
  logic        o_dataValid;
  logic [31:0] o_DATA;
  logic        i_rxValid;
  logic [31:0] i_rxData;
  logic [23:0] o_result;
  logic [3:0]  o_resultCh;
  logic        o_resultValid;
  logic        o_eocErr;
  logic        o_busy;

  logic        m_ready;
  logic        ready_block;

  int checks   = 0;
  int failures = 0;

  int xfer_idx  = 0;
  int eoc_idx   = -1;
  int dv_double = 0;
  bit dv_prev   = 1'b0;

  logic [31:0] word_log[$];
  logic [3:0]  rch_log[$];
  logic [23:0] res_log[$];

  always #5 clk = ~clk;

  assign i_ready = m_ready && !ready_block;

  adc_scan_sequencer #(.CONV_CYCLES(CONV), .CNT_W(4), .NCH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (i_enable),
    .i_chanMask    (i_chanMask),
    .i_gain        (i_gain),
    .i_ready       (i_ready),
    .o_dataValid   (o_dataValid),
    .o_DATA        (o_DATA),
    .i_rxValid     (i_rxValid),
    .i_rxData      (i_rxData),
    .o_result      (o_result),
    .o_resultCh    (o_resultCh),
    .o_resultValid (o_resultValid),
    .o_eocErr      (o_eocErr),
    .o_busy        (o_busy)
  );

  function automatic logic [23:0] res_of(input int idx);
    return {12'hABC, 8'h00, 4'(idx)};
  endfunction

  // Master/ADC model: reply word carries a per-transfer tag in the result field.
  initial begin
    m_ready   = 1'b1;
    i_rxValid = 1'b0;
    i_rxData  = '0;
    forever begin
      @(negedge clk);
      if (rst && o_dataValid) begin
        word_log.push_back(o_DATA);
        m_ready = 1'b0;
        repeat (8) @(negedge clk);
        i_rxData  = {(xfer_idx == eoc_idx), 1'b1, res_of(xfer_idx), 6'h15};
        i_rxValid = 1'b1;
        @(negedge clk);
        i_rxValid = 1'b0;
        m_ready   = 1'b1;
        xfer_idx++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && o_resultValid) begin
      rch_log.push_back(o_resultCh);
      res_log.push_back(o_result);
    end
    if (o_dataValid && dv_prev) dv_double++;
    dv_prev = o_dataValid;
  end

  task automatic clear_logs();
    word_log.delete();
    rch_log.delete();
    res_log.delete();
  endtask

  task automatic wait_results(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (res_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (word_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    i_enable    = 1'b0;
    i_chanMask  = '0;
    i_gain      = '0;
    ready_block = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_dataValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_dataValid got=%b exp=0", o_dataValid); end
    checks++; if (o_DATA !== 32'h8000_0000) begin failures++; $display("[TB] FAIL reset_DATA got=%h exp=80000000", o_DATA); end
    checks++; if (o_result !== 24'h0) begin failures++; $display("[TB] FAIL reset_result got=%h exp=0", o_result); end
    checks++; if (o_resultCh !== 4'h0) begin failures++; $display("[TB] FAIL reset_resultCh got=%h exp=0", o_resultCh); end
    checks++; if (o_resultValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_resultValid got=%b exp=0", o_resultValid); end
    checks++; if (o_eocErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_eocErr got=%b exp=0", o_eocErr); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", o_busy); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_scan_two();
    bit ok;
    int base;
    logic [31:0] exp_w[4];
    logic [3:0]  exp_c[3];
    logic [31:0] gw;
    logic [3:0]  gc;
    logic [23:0] gr;
    exp_w = '{32'hB843_0000, 32'hB8C3_0000, 32'hB843_0000, 32'hB8C3_0000};
    exp_c = '{4'd0, 4'd2, 4'd0};
    clear_logs();
    base       = xfer_idx;
    i_chanMask = 16'h0005;
    i_gain     = 3'b110;
    i_enable   = 1'b1;
    wait_results(3, 400, ok);
    i_enable = 1'b0;
    checks++; if (!ok) begin failures++; $display("[TB] FAIL scan_two_timeout got=%0d results exp=3", res_log.size()); end
    wait_idle(100, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL scan_two_idle got=busy exp=idle"); end
    checks++; if (word_log.size() != 4) begin failures++; $display("[TB] FAIL scan_two_words got=%0d exp=4", word_log.size()); end
    for (int i = 0; i < 4; i++) begin
      gw = (i < word_log.size()) ? word_log[i] : 'x;
      checks++; if (gw !== exp_w[i]) begin failures++; $display("[TB] FAIL scan_two_word%0d got=%h exp=%h", i, gw, exp_w[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      gc = (i < rch_log.size()) ? rch_log[i] : 'x;
      gr = (i < res_log.size()) ? res_log[i] : 'x;
      checks++; if (gc !== exp_c[i]) begin failures++; $display("[TB] FAIL scan_two_ch%0d got=%0d exp=%0d", i, gc, exp_c[i]); end
      checks++; if (gr !== res_of(base + 1 + i)) begin failures++; $display("[TB] FAIL scan_two_res%0d got=%h exp=%h", i, gr, res_of(base + 1 + i)); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] exp_w[3];
    logic [3:0]  exp_c[2];
    logic [31:0] gw;
    logic [3:0]  gc;
    exp_w = '{32'hB841_8000, 32'hBFC1_8000, 32'hB841_8000};
    exp_c = '{4'd0, 4'd15};
    clear_logs();
    i_chanMask = 16'h8001;
    i_gain     = 3'b011;
    i_enable   = 1'b1;
    wait_results(2, 400, ok);
    i_enable = 1'b0;
    checks++; if (!ok) begin failures++; $display("[TB] FAIL wrap_timeout got=%0d results exp=2", res_log.size()); end
    wait_idle(100, ok);
    checks++; if (word_log.size() != 3) begin failures++; $display("[TB] FAIL wrap_words got=%0d exp=3", word_log.size()); end
    for (int i = 0; i < 3; i++) begin
      gw = (i < word_log.size()) ? word_log[i] : 'x;
      checks++; if (gw !== exp_w[i]) begin failures++; $display("[TB] FAIL wrap_word%0d got=%h exp=%h", i, gw, exp_w[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      gc = (i < rch_log.size()) ? rch_log[i] : 'x;
      checks++; if (gc !== exp_c[i]) begin failures++; $display("[TB] FAIL wrap_ch%0d got=%0d exp=%0d", i, gc, exp_c[i]); end
    end
  endtask

  task automatic test_zero_mask();
    int busy_seen;
    clear_logs();
    busy_seen  = 0;
    i_chanMask = 16'h0000;
    i_enable   = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_busy) busy_seen++;
    end
    checks++; if (busy_seen != 0) begin failures++; $display("[TB] FAIL zero_mask_busy got=%0d busy cycles exp=0", busy_seen); end
    checks++; if (word_log.size() != 0) begin failures++; $display("[TB] FAIL zero_mask_words got=%0d exp=0", word_log.size()); end
    ready_block = 1'b1;
    i_chanMask  = 16'h0001;
    repeat (3) @(negedge clk);
    checks++; if (o_busy !== 1'b1) begin failures++; $display("[TB] FAIL issue_wait_busy got=%b exp=1", o_busy); end
    i_chanMask = 16'h0000;
    repeat (2) @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin failures++; $display("[TB] FAIL issue_abort_busy got=%b exp=0", o_busy); end
    i_enable    = 1'b0;
    ready_block = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (word_log.size() != 0) begin failures++; $display("[TB] FAIL issue_abort_words got=%0d exp=0", word_log.size()); end
  endtask

  task automatic test_eoc();
    bit ok;
    int base;
    logic [3:0]  gc;
    logic [23:0] gr;
    clear_logs();
    base       = xfer_idx;
    eoc_idx    = base + 2;
    i_chanMask = 16'h0006;
    i_gain     = 3'b001;
    i_enable   = 1'b1;
    wait_results(2, 400, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL eoc_timeout got=%0d results exp=2", res_log.size()); end
    checks++; if (o_eocErr !== 1'b1) begin failures++; $display("[TB] FAIL eoc_flag_running got=%b exp=1", o_eocErr); end
    i_enable = 1'b0;
    wait_idle(100, ok);
    eoc_idx = -1;
    checks++; if (o_eocErr !== 1'b1) begin failures++; $display("[TB] FAIL eoc_flag_sticky got=%b exp=1", o_eocErr); end
    checks++; if (word_log.size() != 4) begin failures++; $display("[TB] FAIL eoc_words got=%0d exp=4", word_log.size()); end
    gc = (rch_log.size() > 0) ? rch_log[0] : 'x;
    gr = (res_log.size() > 0) ? res_log[0] : 'x;
    checks++; if (gc !== 4'd1) begin failures++; $display("[TB] FAIL eoc_ch0 got=%0d exp=1", gc); end
    checks++; if (gr !== res_of(base + 1)) begin failures++; $display("[TB] FAIL eoc_res0 got=%h exp=%h", gr, res_of(base + 1)); end
    gc = (rch_log.size() > 1) ? rch_log[1] : 'x;
    gr = (res_log.size() > 1) ? res_log[1] : 'x;
    checks++; if (gc !== 4'd1) begin failures++; $display("[TB] FAIL eoc_ch1 got=%0d exp=1", gc); end
    checks++; if (gr !== res_of(base + 3)) begin failures++; $display("[TB] FAIL eoc_res1 got=%h exp=%h", gr, res_of(base + 3)); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int base;
    logic [31:0] gw;
    logic [3:0]  gc;
    logic [23:0] gr;
    clear_logs();
    base       = xfer_idx;
    i_chanMask = 16'h0010;
    i_gain     = 3'b000;
    i_enable   = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (o_eocErr !== 1'b0) begin failures++; $display("[TB] FAIL eoc_cleared_on_start got=%b exp=0", o_eocErr); end
    wait_words(2, 400, ok);
    i_enable = 1'b0;
    checks++; if (!ok) begin failures++; $display("[TB] FAIL drop_timeout got=%0d words exp=2", word_log.size()); end
    checks++; if (o_busy !== 1'b1) begin failures++; $display("[TB] FAIL drop_in_xfer_busy got=%b exp=1", o_busy); end
    wait_idle(100, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL drop_idle got=busy exp=idle"); end
    repeat (50) @(negedge clk);
    checks++; if (word_log.size() != 2) begin failures++; $display("[TB] FAIL drop_words got=%0d exp=2", word_log.size()); end
    for (int i = 0; i < 2; i++) begin
      gw = (i < word_log.size()) ? word_log[i] : 'x;
      checks++; if (gw !== 32'hB940_0000) begin failures++; $display("[TB] FAIL drop_word%0d got=%h exp=b9400000", i, gw); end
    end
    checks++; if (res_log.size() != 1) begin failures++; $display("[TB] FAIL drop_results got=%0d exp=1", res_log.size()); end
    gc = (rch_log.size() > 0) ? rch_log[0] : 'x;
    gr = (res_log.size() > 0) ? res_log[0] : 'x;
    checks++; if (gc !== 4'd4) begin failures++; $display("[TB] FAIL drop_ch got=%0d exp=4", gc); end
    checks++; if (gr !== res_of(base + 1)) begin failures++; $display("[TB] FAIL drop_res got=%h exp=%h", gr, res_of(base + 1)); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int base;
    logic [31:0] gw;
    logic [3:0]  gc;
    logic [23:0] gr;
    clear_logs();
    i_chanMask = 16'h0005;
    i_gain     = 3'b110;
    i_enable   = 1'b1;
    wait_results(1, 400, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL rst_mid_timeout got=%0d results exp=1", res_log.size()); end
    @(negedge clk);
    checks++; if (o_busy !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_pre_busy got=%b exp=1", o_busy); end
    rst = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy got=%b exp=0", o_busy); end
    checks++; if (o_DATA !== 32'h8000_0000) begin failures++; $display("[TB] FAIL rst_mid_DATA got=%h exp=80000000", o_DATA); end
    checks++; if (o_result !== 24'h0) begin failures++; $display("[TB] FAIL rst_mid_result got=%h exp=0", o_result); end
    checks++; if (o_resultCh !== 4'h0) begin failures++; $display("[TB] FAIL rst_mid_resultCh got=%h exp=0", o_resultCh); end
    checks++; if (o_resultValid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_resultValid got=%b exp=0", o_resultValid); end
    checks++; if (o_dataValid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_dataValid got=%b exp=0", o_dataValid); end
    repeat (2) @(negedge clk);
    clear_logs();
    base = xfer_idx;
    rst  = 1'b1;
    wait_results(1, 400, ok);
    i_enable = 1'b0;
    checks++; if (!ok) begin failures++; $display("[TB] FAIL restart_timeout got=%0d results exp=1", res_log.size()); end
    wait_idle(100, ok);
    gw = (word_log.size() > 0) ? word_log[0] : 'x;
    gc = (rch_log.size() > 0) ? rch_log[0] : 'x;
    gr = (res_log.size() > 0) ? res_log[0] : 'x;
    checks++; if (gw !== 32'hB843_0000) begin failures++; $display("[TB] FAIL restart_word0 got=%h exp=b8430000", gw); end
    checks++; if (gc !== 4'd0) begin failures++; $display("[TB] FAIL restart_ch got=%0d exp=0", gc); end
    checks++; if (gr !== res_of(base + 1)) begin failures++; $display("[TB] FAIL restart_res got=%h exp=%h", gr, res_of(base + 1)); end
  endtask

  task automatic test_pulse_width();
    checks++; if (dv_double != 0) begin failures++; $display("[TB] FAIL dataValid_width got=%0d long pulses exp=0", dv_double); end
  endtask

  initial begin
    test_reset();
    test_scan_two();
    test_wrap();
    test_zero_mask();
    test_eoc();
    test_enable_drop();
    test_reset_mid_wait();
    test_pulse_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
